// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared definitions for the two-port RAM arbiter: the arbiter
//               state encoding and the default RAM geometry shared with the
//               RAM instance in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Default RAM geometry, shared by the arbiter and the RAM it fronts.
    localparam int c_RAM_VEC_WIDTH  = 264;
    localparam int c_RAM_ADDR_WIDTH = 11;

    // Arbiter states: nobody owns the RAM, or port 0 / port 1 owns it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-port round-robin arbiter in front of a single-port RAM
//               with one-cycle read latency. Grants are combinational from
//               the current requests and registered state; an owner may keep
//               the RAM for up to MAX_BURST consecutive grants while the other
//               port waits.
// Ports       : i_clk, i_rst_n           clock, async active-low reset
//               i_pk_req/we/addr/wdata   port k request (k = 0,1)
//               o_pk_gnt                 port k request accepted this cycle
//               o_pk_rvalid              port k read data present on o_rdata
//               o_rdata                  shared read data
//               o_ram_we/addr/wdata      RAM command from the granted port
//               i_ram_rdata              RAM read data (one cycle after read)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int VEC_WIDTH  = c_RAM_VEC_WIDTH,
    parameter int ADDR_WIDTH = c_RAM_ADDR_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_p0_req,
    input  logic                  i_p0_we,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [VEC_WIDTH-1:0]  i_p0_wdata,
    output logic                  o_p0_gnt,
    output logic                  o_p0_rvalid,

    input  logic                  i_p1_req,
    input  logic                  i_p1_we,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [VEC_WIDTH-1:0]  i_p1_wdata,
    output logic                  o_p1_gnt,
    output logic                  o_p1_rvalid,

    output logic [VEC_WIDTH-1:0]  o_rdata,

    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [VEC_WIDTH-1:0]  o_ram_wdata,
    input  logic [VEC_WIDTH-1:0]  i_ram_rdata
);

    localparam logic [3:0] c_MAX = 4'(MAX_BURST);

    arb_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       rvalid0_q, rvalid1_q;

    logic       w_pick0;
    logic       w_pick1;
    logic       w_gnt0;
    logic       w_gnt1;
    logic [3:0] w_cnt_inc;

    // Round-robin pick from the current requests and the registered state.
    always_comb begin
        w_pick0 = 1'b0;
        w_pick1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_p0_req && i_p1_req) begin
                    // Tie from idle goes to the port that did not win last.
                    w_pick0 = last_q;
                    w_pick1 = !last_q;
                end else begin
                    w_pick0 = i_p0_req;
                    w_pick1 = i_p1_req;
                end
            end
            OWN0: begin
                if (i_p0_req && ((cnt_q < c_MAX) || !i_p1_req)) begin
                    w_pick0 = 1'b1;
                end else begin
                    w_pick1 = i_p1_req;
                end
            end
            OWN1: begin
                if (i_p1_req && ((cnt_q < c_MAX) || !i_p0_req)) begin
                    w_pick1 = 1'b1;
                end else begin
                    w_pick0 = i_p0_req;
                end
            end
            default: begin
                w_pick0 = 1'b0;
                w_pick1 = 1'b0;
            end
        endcase
    end

    // Requests are ignored entirely while reset is held, so neither a grant
    // nor a RAM write can leak out during reset.
    assign w_gnt0 = w_pick0 & i_rst_n;
    assign w_gnt1 = w_pick1 & i_rst_n;

    assign w_cnt_inc = (cnt_q < c_MAX) ? (cnt_q + 4'd1) : cnt_q;

    // Ownership follows the grant; a change of owner restarts the burst.
    always_comb begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        last_d  = last_q;
        if (w_gnt0) begin
            state_d = OWN0;
            last_d  = 1'b0;
            cnt_d   = (state_q == OWN0) ? w_cnt_inc : 4'd1;
        end else if (w_gnt1) begin
            state_d = OWN1;
            last_d  = 1'b1;
            cnt_d   = (state_q == OWN1) ? w_cnt_inc : 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rvalid0_q <= w_gnt0 & ~i_p0_we;
            rvalid1_q <= w_gnt1 & ~i_p1_we;
        end
    end

    assign o_p0_gnt    = w_gnt0;
    assign o_p1_gnt    = w_gnt1;
    assign o_p0_rvalid = rvalid0_q;
    assign o_p1_rvalid = rvalid1_q;

    // The RAM returns data one cycle after the read grant, aligned with rvalid.
    assign o_rdata = i_ram_rdata;

    assign o_ram_we    = w_gnt0 ? i_p0_we    : (w_gnt1 ? i_p1_we    : 1'b0);
    assign o_ram_addr  = w_gnt0 ? i_p0_addr  : (w_gnt1 ? i_p1_addr  : '0);
    assign o_ram_wdata = w_gnt0 ? i_p0_wdata : (w_gnt1 ? i_p1_wdata : '0);

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter with a behavioural
//               single-port RAM, directed sequences, an arbitration vector
//               table and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int VW    = 32;
    localparam int AW    = 6;
    localparam int MB    = 4;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [VW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [VW-1:0] rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [VW-1:0] ram_wdata;
    logic [VW-1:0] ram_rdata;
    logic          ram_init = 1'b0;

    logic [VW-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .VEC_WIDTH (VW),
        .ADDR_WIDTH(AW),
        .MAX_BURST (MB)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_p0_req   (p0_req),
        .i_p0_we    (p0_we),
        .i_p0_addr  (p0_addr),
        .i_p0_wdata (p0_wdata),
        .o_p0_gnt   (p0_gnt),
        .o_p0_rvalid(p0_rvalid),
        .i_p1_req   (p1_req),
        .i_p1_we    (p1_we),
        .i_p1_addr  (p1_addr),
        .i_p1_wdata (p1_wdata),
        .o_p1_gnt   (p1_gnt),
        .o_p1_rvalid(p1_rvalid),
        .o_rdata    (rdata),
        .o_ram_we   (ram_we),
        .o_ram_addr (ram_addr),
        .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata)
    );

    function automatic logic [VW-1:0] init_val(input int i);
        if (i == 5) return 32'hA5;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // Single-port RAM: write on we, registered read on !we.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end else begin
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic r0;
        logic r1;
        logic g0;
        logic g1;
    } vec_t;

    vec_t tbl [19];

    // Reference model state for the random phase.
    int            m_last;
    int            m_run;
    logic [VW-1:0] shadow [DEPTH];

    // Both requesting: the current owner keeps the RAM until it has had MB
    // consecutive grants; from idle the port that did not win last goes.
    function automatic int model_pick(input logic r0, input logic r1);
        if (r0 && r1) begin
            if (m_run == 0 || m_run >= MB) return (m_last == 1) ? 0 : 1;
            return m_last;
        end
        if (r0) return 0;
        if (r1) return 1;
        return 2;
    endfunction

    initial begin
        logic          prev_g0, prev_g1;
        logic          pend  [2];
        logic          pwe   [2];
        logic [AW-1:0] padr  [2];
        logic [VW-1:0] pdat  [2];
        int            waitc [2];
        int            max_wait;
        logic          exp_rv [2];
        logic [VW-1:0] exp_rd;
        logic          nrv [2];
        logic [VW-1:0] nrd;
        int            eg;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b1};

        idle_inputs();
        rst_n    = 1'b0;
        ram_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ram_init = 1'b0;

        // Requests held during reset must not produce grants or RAM writes.
        p0_req = 1'b1; p1_req = 1'b1; p1_we = 1'b1;
        #2;
        chk("rst_gnt0",   64'(p0_gnt),    64'd0);
        chk("rst_gnt1",   64'(p1_gnt),    64'd0);
        chk("rst_ram_we", 64'(ram_we),    64'd0);
        chk("rst_rv0",    64'(p0_rvalid), 64'd0);
        chk("rst_rv1",    64'(p1_rvalid), 64'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Read of addr 5 right after reset.
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 6'd5;
        @(negedge clk);
        chk("rd5_gnt0", 64'(p0_gnt), 64'd1);
        chk("rd5_gnt1", 64'(p1_gnt), 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("rd5_rv0",   64'(p0_rvalid), 64'd1);
        chk("rd5_rv1",   64'(p1_rvalid), 64'd0);
        chk("rd5_rdata", 64'(rdata),     64'hA5);

        // p1 writes addr 7, p0 reads it back on the next cycle.
        @(posedge clk); #1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 6'd7; p1_wdata = 32'h3C;
        @(negedge clk);
        chk("wr7_gnt1",  64'(p1_gnt),   64'd1);
        chk("wr7_we",    64'(ram_we),   64'd1);
        chk("wr7_addr",  64'(ram_addr), 64'd7);
        @(posedge clk); #1;
        idle_inputs();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 6'd7;
        @(negedge clk);
        chk("raw_gnt0", 64'(p0_gnt),    64'd1);
        chk("raw_rv1",  64'(p1_rvalid), 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("raw_rv0",   64'(p0_rvalid), 64'd1);
        chk("raw_rdata", 64'(rdata),     64'h3C);

        // Arbitration vector table from a fresh reset.
        pulse_reset();
        prev_g0 = 1'b0;
        prev_g1 = 1'b0;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            p0_req = tbl[i].r0; p0_we = 1'b0; p0_addr = 6'd1;
            p1_req = tbl[i].r1; p1_we = 1'b0; p1_addr = 6'd2;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt0", i), 64'(p0_gnt), 64'(tbl[i].g0));
            chk($sformatf("tbl%0d_gnt1", i), 64'(p1_gnt), 64'(tbl[i].g1));
            chk($sformatf("tbl%0d_addr", i), 64'(ram_addr),
                tbl[i].g0 ? 64'd1 : (tbl[i].g1 ? 64'd2 : 64'd0));
            chk($sformatf("tbl%0d_rv0", i), 64'(p0_rvalid), 64'(prev_g0));
            chk($sformatf("tbl%0d_rv1", i), 64'(p1_rvalid), 64'(prev_g1));
            prev_g0 = tbl[i].g0;
            prev_g1 = tbl[i].g1;
        end

        // Read granted, then reset before the edge that would launch rvalid.
        @(posedge clk); #1;
        idle_inputs();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 6'd3;
        @(negedge clk);
        chk("rstrd_gnt0", 64'(p0_gnt), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstrd_gnt0_in_rst", 64'(p0_gnt), 64'd0);
        @(posedge clk); #1;
        chk("rstrd_rv0_in_rst", 64'(p0_rvalid), 64'd0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rstrd_rv0_after%0d", i), 64'(p0_rvalid), 64'd0);
        end
        @(posedge clk); #1;
        p0_req = 1'b1; p1_req = 1'b1;
        @(negedge clk);
        chk("rstrd_tie_gnt0", 64'(p0_gnt), 64'd1);
        chk("rstrd_tie_gnt1", 64'(p1_gnt), 64'd0);

        // Randomized traffic against the reference model.
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) shadow[i] = mem[i];
        m_last   = 1;
        m_run    = 0;
        max_wait = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; waitc[p] = 0; exp_rv[p] = 1'b0;
            pwe[p] = 1'b0; padr[p] = '0; pdat[p] = '0;
        end
        exp_rd = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(3) != 0)) begin
                    pend[p] = 1'b1;
                    pwe[p]  = 1'($urandom_range(1));
                    padr[p] = AW'($urandom_range(DEPTH - 1));
                    pdat[p] = $urandom;
                end
            end
            p0_req   = pend[0];
            p0_we    = pend[0] ? pwe[0]  : 1'($urandom_range(1));
            p0_addr  = pend[0] ? padr[0] : AW'($urandom_range(DEPTH - 1));
            p0_wdata = pend[0] ? pdat[0] : $urandom;
            p1_req   = pend[1];
            p1_we    = pend[1] ? pwe[1]  : 1'($urandom_range(1));
            p1_addr  = pend[1] ? padr[1] : AW'($urandom_range(DEPTH - 1));
            p1_wdata = pend[1] ? pdat[1] : $urandom;

            @(negedge clk);
            eg = model_pick(pend[0], pend[1]);
            chk("rnd_gnt0", 64'(p0_gnt), (eg == 0) ? 64'd1 : 64'd0);
            chk("rnd_gnt1", 64'(p1_gnt), (eg == 1) ? 64'd1 : 64'd0);
            chk("rnd_collision", 64'(p0_gnt & p1_gnt), 64'd0);
            chk("rnd_rv0", 64'(p0_rvalid), 64'(exp_rv[0]));
            chk("rnd_rv1", 64'(p1_rvalid), 64'(exp_rv[1]));
            if (exp_rv[0] || exp_rv[1]) chk("rnd_rdata", 64'(rdata), 64'(exp_rd));
            if (eg == 2) begin
                chk("rnd_idle_we", 64'(ram_we), 64'd0);
            end else begin
                chk("rnd_ram_we",   64'(ram_we),   64'(pwe[eg]));
                chk("rnd_ram_addr", 64'(ram_addr), 64'(padr[eg]));
                if (pwe[eg]) chk("rnd_ram_wdata", 64'(ram_wdata), 64'(pdat[eg]));
            end

            nrv[0] = 1'b0;
            nrv[1] = 1'b0;
            nrd    = '0;
            if (eg != 2) begin
                if (pwe[eg]) begin
                    shadow[padr[eg]] = pdat[eg];
                end else begin
                    nrv[eg] = 1'b1;
                    nrd     = shadow[padr[eg]];
                end
                pend[eg]  = 1'b0;
                waitc[eg] = 0;
                if (m_run > 0 && eg == m_last) m_run = (m_run < MB) ? m_run + 1 : MB;
                else                           m_run = 1;
                m_last = eg;
            end else begin
                m_run = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) begin
                    waitc[p]++;
                    if (waitc[p] > max_wait) max_wait = waitc[p];
                end
            end
            exp_rv[0] = nrv[0];
            exp_rv[1] = nrv[1];
            exp_rd    = nrd;
        end
        chk("rnd_max_wait_exceeded", 64'(max_wait > MB), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter VEC_WIDTH, default 264, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, RAM address width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum consecutive grants to one owner while the other port waits; legal range 1..15.
REQ-004 SHALL have ports: i_clk  in  1  single clock, all logic on rising edge; i_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have, for each k in {0,1}: i_pk_req  in  1  request valid; i_pk_we  in  1  1=write, 0=read; i_pk_addr  in  ADDR_WIDTH  address; i_pk_wdata  in  VEC_WIDTH  write data.
REQ-006 SHALL have, for each k in {0,1}: o_pk_gnt  out  1  request accepted this cycle; o_pk_rvalid  out  1  read data for port k on o_rdata.
REQ-007 SHALL have o_rdata  out  VEC_WIDTH  shared read data, valid only when an o_pk_rvalid is high.
REQ-008 SHALL have RAM-side ports: o_ram_we  out  1; o_ram_addr  out  ADDR_WIDTH; o_ram_wdata  out  VEC_WIDTH; i_ram_rdata  in  VEC_WIDTH. These connect to a single-port RAM that writes on we=1, reads on we=0, and returns read data one cycle later.

Function
REQ-009 SHALL grant at most one port per cycle; o_p0_gnt and o_p1_gnt SHALL never both be 1.
REQ-010 SHALL compute o_pk_gnt combinationally from the current requests and the registered state; a request is consumed in the cycle its grant is high.
REQ-011 SHALL drive o_ram_we/addr/wdata combinationally from the granted port; with no grant, o_ram_we=0 and addr/wdata=0.
REQ-012 SHALL assert o_pk_rvalid exactly one cycle after a read grant to port k, and drive o_rdata = i_ram_rdata; write grants produce no rvalid.
REQ-013 SHALL keep states IDLE, OWN0, OWN1, a burst counter cnt (4 bits), and a last-owner register last.
REQ-014 In IDLE: if only port k requests, grant k. If both request, grant the port != last. Then go to OWNk with cnt=1.
REQ-015 In OWNk, owner requesting, and (cnt<MAX_BURST or other idle): grant k, with cnt saturating at MAX_BURST.
REQ-016 In OWNk, owner requesting, cnt==MAX_BURST, and other requesting: grant other, go to OWNother with cnt=1.
REQ-017 In OWNk with owner not requesting: if other requests, grant it and go to OWNother with cnt=1; else go to IDLE with cnt=0.
REQ-018 SHALL update last to the granted port on every grant.
REQ-019 SHALL allow read-after-write to the same address in consecutive cycles; the RAM ordering returns the new data with no bypass logic.
REQ-020 SHALL treat i_pk_we, addr and wdata as don't-care while i_pk_req=0.

Reset
REQ-021 While i_rst_n=0: state=IDLE, cnt=0, last=1 (so p0 wins the first tie), o_p0_rvalid=o_p1_rvalid=0, o_p0_gnt=o_p1_gnt=0, and o_ram_we=0.
REQ-022 Reset asserted mid-burst or with a read in flight SHALL drop the pending rvalid; after release, no rvalid is produced for pre-reset grants.

Structure
REQ-023 State encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) SHALL live in shared package ram_arb_pkg, alongside the default VEC_WIDTH/ADDR_WIDTH constants shared with the RAM.
REQ-024 SHALL contain no sub-module; the RAM is instantiated by the parent, and the round-robin pick is local logic.

Verification
REQ-025 Reset release, p0 read addr 5 (mem[5]=0xA5) -> p0_gnt in same cycle, p0_rvalid next cycle, o_rdata=0xA5.
REQ-026 p0 and p1 both request from IDLE after reset -> p0 granted first; after p0 drops, p1 granted next cycle.
REQ-027 p0 requests continuously with p1 requesting, MAX_BURST=4 -> grants p0,p0,p0,p0,p1,p1,p1,p1,p0... with no two-port grant ever.
REQ-028 p1 writes 0x3C to addr 7, then p0 reads addr 7 on the next cycle -> p0_rvalid with o_rdata=0x3C.
REQ-029 p0 read granted, reset pulsed before the next edge -> no rvalid after release; state IDLE, p0 wins the next tie.
REQ-030 Random req/we traffic for 10k cycles against a scoreboard RAM model -> all read data matches, no grant collisions, and no port waits more than MAX_BURST cycles while requesting.
